// File: rtl/trotrig_uart_tap_if.sv
// Output bundle of the UART tap: the character byte and its two strobes,
// in the form the trojan trigger counter consumes.
//   din       : last correctly framed character
//   enable    : one-cycle strobe, din newly updated in the same cycle
//   frame_err : one-cycle strobe on a stop-bit violation
// master = the tap driving the bundle, slave = the consumer.
interface trotrig_uart_tap_if #(
   parameter int DINBITS = 8
);
   logic [DINBITS-1:0] din;
   logic               enable;
   logic               frame_err;

   modport master (output din, enable, frame_err);
   modport slave  (input  din, enable, frame_err);
endinterface

// File: rtl/trotrig_uart_tap.sv
// Passive UART (8N1-style, LSB first) deframer feeding the trigger counter.
// Each good character appears on tap.din with a one-cycle tap.enable;
// a frame whose stop bit is low is dropped and flagged on tap.frame_err.
// Ports:
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   rx     : raw serial line, asynchronous to clk, idles high
//   tap    : output bundle (din / enable / frame_err), master side
module trotrig_uart_tap #(
   parameter int DINBITS      = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               rx,
   trotrig_uart_tap_if.master tap
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DINBITS > 1) ? $clog2(DINBITS) : 1;

   localparam logic [TW-1:0] T_HALF   = TW'(H - 1);
   localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DINBITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic               sync1_q, sync2_q;
   logic               rx_s;
   logic [2:0]         state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [DINBITS-1:0] shift_q, shift_d;
   logic [DINBITS-1:0] din_q, din_d;
   logic               enable_q, enable_d;
   logic               ferr_q, ferr_d;

   assign rx_s = sync2_q;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      din_d    = din_q;
      enable_d = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               timer_d = T_HALF;
            end
         end
         S_START: begin
            if (timer_q == '0) begin
               // A start bit that is high again at its midpoint was a glitch.
               if (!rx_s) begin
                  state_d = S_DATA;
                  timer_d = T_FULL;
                  idx_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_DATA: begin
            if (timer_q == '0) begin
               // LSB arrives first: shifting right leaves it at bit 0.
               shift_d = {rx_s, shift_q[DINBITS-1:1]};
               timer_d = T_FULL;
               if (idx_q == IDX_LAST) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_STOP: begin
            // Leaving at the stop-bit midpoint allows back-to-back frames.
            if (timer_q == '0) begin
               if (rx_s) begin
                  din_d    = shift_q;
                  enable_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_BREAK: begin
            // Wait out a held-low line so a break flags only once.
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= S_IDLE;
         timer_q  <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         din_q    <= '0;
         enable_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         sync1_q  <= rx;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         din_q    <= din_d;
         enable_q <= enable_d;
         ferr_q   <= ferr_d;
      end
   end

   assign tap.din       = din_q;
   assign tap.enable    = enable_q;
   assign tap.frame_err = ferr_q;

endmodule

// File: doc/trotrig_uart_tap.md
# trotrig_uart_tap

- Serial-tap front end that feeds the trojan trigger counter.
- Passively snoops an asynchronous UART line (8N1-style, LSB first) and deframes each character.
- Presents each good character as a `din` byte with a single-cycle `enable` strobe, the exact form the trigger's `din`/`enable` inputs consume.
- Malformed frames are dropped and flagged on `frame_err`; they never produce a strobe.

## Interface

Parameters:
- `DINBITS`, default 8: data bits per character; equals the trigger's `din` width.
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit.
  - Must be even and ≥ 4.
  - `H = CLKS_PER_BIT/2`.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: raw serial line, asynchronous to `clk`; idles high.
- `din`, output, `DINBITS`: last correctly framed character, registered.
- `enable`, output, 1: one-cycle strobe; `din` is valid and newly updated in the same cycle.
- `frame_err`, output, 1: one-cycle strobe on a stop-bit violation.

## Operation

Reset:
- While `resetn`=0: all flops are cleared asynchronously.
  - `din`=0, `enable`=0, `frame_err`=0.
  - FSM=IDLE, both synchronizer flops=1.
- Reset has immediate effect mid-frame. A partial character is discarded and no strobe is issued.

Synchronizer:
- `rx` passes through two flops to give `rx_s`.
- Only `rx_s` is used internally.

Datapath:
- Bit-timer counter, `$clog2(CLKS_PER_BIT)` bits wide.
- Bit index, 0..DINBITS-1.
- Shift register, `DINBITS` wide. Sampled bits enter at the MSB and shift right, so the first received bit ends at bit 0.

FSM:
- IDLE: if `rx_s`=0, go to START and load timer=H-1.
- START: decrement the timer. At timer=0, sample `rx_s`:
  - 0: go to DATA with timer=CLKS_PER_BIT-1 and index=0.
  - 1: treat as a glitch and return to IDLE silently.
- DATA: decrement the timer. At timer=0:
  - Shift in `rx_s` and reload timer=CLKS_PER_BIT-1.
  - If index=DINBITS-1, go to STOP; otherwise increment the index.
- STOP: decrement the timer. At timer=0, sample `rx_s`:
  - 1: `din`←shift register, pulse `enable`, go to IDLE.
  - 0: pulse `frame_err`, leave `din` unchanged, go to BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. A held-low line (break) yields exactly one `frame_err`.

Other rules:
- Returning to IDLE at the stop-bit midpoint lets a following start bit be detected with no idle gap. Back-to-back characters at full line rate are supported.
- `enable` and `frame_err` are mutually exclusive and never high for two consecutive cycles.

## Timing

- Define T as the cycle in which IDLE sees `rx_s`=0. `rx_s` lags `rx` by 2 cycles.
- Sample points:
  - Start-bit check at T+H.
  - Data bit k (k=1..DINBITS) at T+H+k·CLKS_PER_BIT.
  - Stop bit at T+H+(DINBITS+1)·CLKS_PER_BIT.
- `enable` or `frame_err` is high in the cycle after the stop sample, i.e. T+H+(DINBITS+1)·CLKS_PER_BIT+1. With defaults this is T+153.
- `din` changes only in the same cycle `enable` rises, and holds until the next `enable`.
- Glitch rejection: a low pulse on `rx_s` shorter than H cycles that is high again at T+H produces no output.
- Sampling tolerates line-rate error up to about ±(H−1)/((DINBITS+1)·CLKS_PER_BIT) cumulative offset at the stop bit.

## Test plan

- Defaults, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 cycles per bit:
  - `enable` high exactly 1 cycle at T+153, with `din`=0xA5.
  - `frame_err` stays 0.
- Glitch: hold `rx` low for 4 cycles, then high:
  - No `enable` and no `frame_err`.
  - FSM back in IDLE by T+9.
  - A following 0x3C is received correctly.
- Framing error: send 0x55 with stop bit 0, then hold low 100 cycles, then high:
  - Exactly one `frame_err` pulse at T+153.
  - `din` keeps its previous value (0 after reset) and no `enable`.
  - The next 0x0F after the line returns high is received.
- Back-to-back: 0x00 then 0xFF, each with a 1-bit stop and no gap:
  - Two `enable` pulses 160 cycles apart.
  - `din`=0x00, then `din`=0xFF.
- Reset mid-frame: assert `resetn`=0 asynchronously during data bit 4 of 0x81:
  - `din`=0 and `enable`=0 immediately.
  - No strobe for the aborted frame.
  - After release, 0x81 is received correctly.
- Parameter sweep CLKS_PER_BIT=4, DINBITS=8, byte 0x6B:
  - `enable` at T+2+9·4+1=T+39 with `din`=0x6B.
